al4s3b_wb_aperture_decoder: RTL and testbench

//  Parametrised Wishbone aperture decoder/response mux between the AHB-to-FPGA bridge and N slave IPs.

---
 rtl/al4s3b_wb_aperture_decoder.sv | 184 ++++++++++++++++++
 tb/tb_al4s3b_wb_aperture_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/al4s3b_wb_aperture_decoder.sv
// -----------------------------------------------------------------------------
// al4s3b_wb_aperture_decoder
//
// Wishbone aperture decoder and response mux sitting between the AHB-to-FPGA
// bridge and NUM_SLAVES slave IPs. The byte address field
// WBs_ADR_i[APERWIDTH-1:APERSIZE+2] is compared against each slave's base
// address. The cycle select is one-hot, and the lowest index wins when several
// apertures match. Slave ACK and read data are returned to the bridge
// combinationally, so the response has zero latency.
//
// A bus-timeout FSM ends any cycle that no slave has acknowledged after
// TIMEOUT_CYCLES cycles, counting the first request cycle as cycle 0. It
// answers with DEFAULT_READ_VALUE so that an unmapped or dead slave cannot
// hang the bridge.
//
// Optional feature macro: WB_DECODE_ERR_CAPTURE_EN
//   defined   -> timeouts are recorded in err_flag_o / err_cnt_o / err_adr_o,
//                and err_clr_i clears them
//   undefined -> err_* outputs are tied to 0 and err_clr_i is ignored
//
// Ports
//   WBs_CLK_i      Wishbone clock
//   WBs_RST_N_i    asynchronous active-low reset
//   WBs_ADR_i      bridge byte address
//   WBs_CYC_i      bridge cycle
//   WBs_STB_i      bridge strobe
//   WBs_RD_DAT_o   read data to the bridge
//   WBs_ACK_o      acknowledge to the bridge
//   WBs_CYC_o      one-hot slave cycle select
//   WBs_RD_DAT_i   packed slave read data, slave i at [i*32 +: 32]
//   WBs_ACK_i      slave acknowledges
//   err_clr_i      one-cycle pulse that clears the error capture
//   err_flag_o     sticky timeout flag
//   err_cnt_o      saturating timeout count
//   err_adr_o      address of the last timed-out cycle
// -----------------------------------------------------------------------------
module al4s3b_wb_aperture_decoder #(
    parameter int                            NUM_SLAVES         = 4,
    parameter int                            APERWIDTH          = 17,
    parameter int                            APERSIZE           = 10,
    parameter logic [NUM_SLAVES*APERWIDTH-1:0] BASE_ADDRS       =
        {17'h03000, 17'h02000, 17'h01000, 17'h00000},
    parameter logic [31:0]                   DEFAULT_READ_VALUE = 32'hBADFABAC,
    parameter int                            TIMEOUT_CYCLES     = 7
) (
    input  logic                     WBs_CLK_i,
    input  logic                     WBs_RST_N_i,
    input  logic [APERWIDTH-1:0]     WBs_ADR_i,
    input  logic                     WBs_CYC_i,
    input  logic                     WBs_STB_i,
    output logic [31:0]              WBs_RD_DAT_o,
    output logic                     WBs_ACK_o,
    output logic [NUM_SLAVES-1:0]    WBs_CYC_o,
    input  logic [NUM_SLAVES*32-1:0] WBs_RD_DAT_i,
    input  logic [NUM_SLAVES-1:0]    WBs_ACK_i,
    input  logic                     err_clr_i,
    output logic                     err_flag_o,
    output logic [7:0]               err_cnt_o,
    output logic [APERWIDTH-1:0]     err_adr_o
);

    localparam int DHI = APERWIDTH - 1;
    localparam int DLO = APERSIZE + 2;
    localparam int DW  = DHI - DLO + 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, TOACK} state_t;

    state_t                 state;
    logic [7:0]             cnt;
    logic                   to_ack_q;
    logic                   ack_q;     // WBs_ACK_o seen on the previous cycle

    logic [NUM_SLAVES-1:0]  sel;
    logic                   hit;
    logic [31:0]            sel_dat;
    logic                   slave_ack;
    logic                   to_ack;

    // Aperture decode: priority to the lowest index.
    always_comb begin
        sel     = '0;
        hit     = 1'b0;
        sel_dat = DEFAULT_READ_VALUE;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && (WBs_ADR_i[DHI:DLO] == BASE_ADDRS[i*APERWIDTH+DLO +: DW])) begin
                hit     = 1'b1;
                sel[i]  = 1'b1;
                sel_dat = WBs_RD_DAT_i[i*32 +: 32];
            end
        end
    end

    assign WBs_CYC_o = sel & {NUM_SLAVES{WBs_CYC_i}};
    assign slave_ack = |(WBs_ACK_i & WBs_CYC_o);

    // If a slave acknowledges in the timeout cycle, that ACK takes the place
    // of the timeout: only one ACK reaches the bridge, and it carries slave data.
    assign to_ack       = to_ack_q & ~slave_ack;
    assign WBs_ACK_o    = slave_ack | to_ack;
    assign WBs_RD_DAT_o = (hit && !to_ack) ? sel_dat : DEFAULT_READ_VALUE;

    // The FSM enters TOACK one cycle early, so that to_ack_q is high exactly
    // in cycle TIMEOUT_CYCLES. The counter always holds the number of the
    // current request cycle.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
        if (!WBs_RST_N_i) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            to_ack_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q    <= WBs_ACK_o;
            to_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    // The previous-cycle ACK check stops the tail of a finished
                    // transfer from starting a new timeout.
                    if (WBs_CYC_i && WBs_STB_i && !slave_ack && !ack_q) begin
                        cnt <= 8'd1;
                        if (TO_LAST == 8'd1) begin
                            state    <= TOACK;
                            to_ack_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!WBs_CYC_i || slave_ack) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == TO_LAST) begin
                            state    <= TOACK;
                            to_ack_q <= 1'b1;
                        end
                    end
                end
                TOACK: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

`ifdef WB_DECODE_ERR_CAPTURE_EN
    // The capture happens on the cycle that actually delivers the timeout
    // ACK. A timeout that a late slave ACK suppresses is not recorded. A
    // clear that arrives in the same cycle as a timeout gives way to it.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
        if (!WBs_RST_N_i) begin
            err_flag_o <= 1'b0;
            err_cnt_o  <= 8'd0;
            err_adr_o  <= '0;
        end else if (to_ack) begin
            err_flag_o <= 1'b1;
            err_adr_o  <= WBs_ADR_i;
            if (err_clr_i)
                err_cnt_o <= 8'd1;
            else if (err_cnt_o != 8'hFF)
                err_cnt_o <= err_cnt_o + 8'd1;
        end else if (err_clr_i) begin
            err_flag_o <= 1'b0;
            err_cnt_o  <= 8'd0;
            err_adr_o  <= '0;
        end
    end
`else
    assign err_flag_o = 1'b0;
    assign err_cnt_o  = 8'd0;
    assign err_adr_o  = '0;

    logic unused_ok;
    assign unused_ok = err_clr_i ^ (^WBs_ADR_i);
`endif

endmodule

// File: tb/tb_al4s3b_wb_aperture_decoder.sv
module tb_al4s3b_wb_aperture_decoder;

`ifdef WB_DECODE_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [16:0]  adr = '0;
    logic         cyc = 1'b0;
    logic         stb = 1'b0;
    logic [31:0]  rd_dat_o;
    logic         ack_o;
    logic [3:0]   cyc_o;
    logic [127:0] rd_dat_i = '0;
    logic [3:0]   ack_i = '0;
    logic         err_clr = 1'b0;
    logic         err_flag;
    logic [7:0]   err_cnt;
    logic [16:0]  err_adr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    al4s3b_wb_aperture_decoder dut (
        .WBs_CLK_i    (clk),
        .WBs_RST_N_i  (rst_n),
        .WBs_ADR_i    (adr),
        .WBs_CYC_i    (cyc),
        .WBs_STB_i    (stb),
        .WBs_RD_DAT_o (rd_dat_o),
        .WBs_ACK_o    (ack_o),
        .WBs_CYC_o    (cyc_o),
        .WBs_RD_DAT_i (rd_dat_i),
        .WBs_ACK_i    (ack_i),
        .err_clr_i    (err_clr),
        .err_flag_o   (err_flag),
        .err_cnt_o    (err_cnt),
        .err_adr_o    (err_adr)
    );

    // Inputs are driven 1 ns after the rising edge and checked 1 ns later.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle;
        next_cycle();
        cyc = 1'b0; stb = 1'b0; ack_i = '0; err_clr = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if (ack_o !== 1'b0 || cyc_o !== 4'b0000) begin
            n_fail++; $display("FAIL reset_bus: ack=%b cyc_o=%b want 0/0000", ack_o, cyc_o);
        end
        n_tests++;
        if (err_flag !== 1'b0 || err_cnt !== 8'd0 || err_adr !== 17'd0) begin
            n_fail++; $display("FAIL reset_err: flag=%b cnt=%0d adr=%h want 0", err_flag, err_cnt, err_adr);
        end
        next_cycle();
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_read_slave1;
        next_cycle();
        adr = 17'h01004; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            if (c > 0) next_cycle();
            if (c == 2) begin ack_i = 4'b0010; rd_dat_i[63:32] = 32'h0000_00A5; end
            #1;
            n_tests++;
            if (cyc_o !== 4'b0010) begin
                n_fail++; $display("FAIL rd1_cyc c%0d: got %b want 0010", c, cyc_o);
            end
            n_tests++;
            if (ack_o !== (c == 2)) begin
                n_fail++; $display("FAIL rd1_ack c%0d: got %b want %b", c, ack_o, (c == 2));
            end
        end
        n_tests++;
        if (rd_dat_o !== 32'h0000_00A5) begin
            n_fail++; $display("FAIL rd1_data: got %h want 000000a5", rd_dat_o);
        end
        idle_cycle();
        #1;
        n_tests++;
        if (ack_o !== 1'b0) begin
            n_fail++; $display("FAIL rd1_after: ack=%b want 0", ack_o);
        end
    endtask

    // Unmapped read with the error checks that depend on the build.
    task automatic test_timeout_unmapped;
        next_cycle();
        adr = 17'h1F000; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) next_cycle();
            #1;
            n_tests++;
            if (ack_o !== (c == 7) || cyc_o !== 4'b0000) begin
                n_fail++; $display("FAIL to_ack c%0d: ack=%b cyc_o=%b want %b/0000", c, ack_o, cyc_o, (c == 7));
            end
            n_tests++;
            if (rd_dat_o !== 32'hBADFABAC) begin
                n_fail++; $display("FAIL to_data c%0d: got %h want badfabac", c, rd_dat_o);
            end
        end
        idle_cycle();
        #1;
        n_tests++;
        if (ack_o !== 1'b0 || err_flag !== CAP || err_cnt !== 8'(CAP) ||
            err_adr !== (CAP ? 17'h1F000 : 17'h0)) begin
            n_fail++; $display("FAIL to_err: ack=%b flag=%b cnt=%0d adr=%h want 0/%b/%0d", ack_o, err_flag, err_cnt, err_adr, CAP, CAP);
        end
    endtask

    task automatic test_late_ack;
        next_cycle();
        adr = 17'h00010; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) next_cycle();
            if (c == 7) begin ack_i = 4'b0001; rd_dat_i[31:0] = 32'h1234_5678; end
            #1;
            n_tests++;
            if (ack_o !== (c == 7)) begin
                n_fail++; $display("FAIL late_ack c%0d: got %b want %b", c, ack_o, (c == 7));
            end
        end
        n_tests++;
        if (rd_dat_o !== 32'h1234_5678) begin
            n_fail++; $display("FAIL late_data: got %h want 12345678", rd_dat_o);
        end
        idle_cycle();
        #1;
        n_tests++;
        if (ack_o !== 1'b0 || err_cnt !== 8'(CAP)) begin
            n_fail++; $display("FAIL late_single: ack=%b cnt=%0d want 0/%0d", ack_o, err_cnt, CAP);
        end
    endtask

    task automatic test_cyc_drop;
        next_cycle();
        adr = 17'h02000; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) next_cycle();
            if (c == 3) begin cyc = 1'b0; stb = 1'b0; end
            #1;
            n_tests++;
            if (ack_o !== 1'b0 || cyc_o !== ((c < 3) ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL drop c%0d: ack=%b cyc_o=%b want 0", c, ack_o, cyc_o);
            end
        end
        // The next request must be timed starting from cycle 0 again.
        next_cycle();
        adr = 17'h1F000; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) next_cycle();
            #1;
            n_tests++;
            if (ack_o !== (c == 7)) begin
                n_fail++; $display("FAIL drop_retime c%0d: got %b want %b", c, ack_o, (c == 7));
            end
        end
        idle_cycle();
    endtask

    task automatic run_timeout(input logic [16:0] a, input bit clr_on_ack);
        next_cycle();
        adr = a; cyc = 1'b1; stb = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            if (c == 7) err_clr = clr_on_ack;
        end
        idle_cycle();
    endtask

    task automatic test_saturate_clear;
        for (int k = 0; k < 256; k++) run_timeout(17'h1E004, 1'b0);
        #1;
        n_tests++;
        if (err_cnt !== (CAP ? 8'd255 : 8'd0) || err_flag !== CAP) begin
            n_fail++; $display("FAIL sat_cnt: cnt=%0d flag=%b want %0d/%b", err_cnt, err_flag, CAP ? 255 : 0, CAP);
        end
        next_cycle();
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        #1;
        n_tests++;
        if (err_cnt !== 8'd0 || err_flag !== 1'b0 || err_adr !== 17'd0) begin
            n_fail++; $display("FAIL clr: cnt=%0d flag=%b adr=%h want 0", err_cnt, err_flag, err_adr);
        end
        run_timeout(17'h1C008, 1'b1);
        #1;
        n_tests++;
        if (err_cnt !== 8'(CAP) || err_flag !== CAP || err_adr !== (CAP ? 17'h1C008 : 17'h0)) begin
            n_fail++; $display("FAIL clr_vs_to: cnt=%0d flag=%b adr=%h want %0d", err_cnt, err_flag, err_adr, CAP);
        end
    endtask

    task automatic test_reset_midcycle;
        next_cycle();
        adr = 17'h03000; cyc = 1'b1; stb = 1'b1;
        for (int c = 1; c <= 3; c++) next_cycle();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ack_o !== 1'b0 || cyc_o !== 4'b1000 || err_cnt !== 8'd0 || err_flag !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: ack=%b cyc_o=%b cnt=%0d flag=%b want 0/1000/0/0", ack_o, cyc_o, err_cnt, err_flag);
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        // The request is still active, so it counts as new from release.
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) next_cycle();
            #1;
            n_tests++;
            if (ack_o !== (c == 7)) begin
                n_fail++; $display("FAIL rst_retime c%0d: got %b want %b", c, ack_o, (c == 7));
            end
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_read_slave1();
        test_timeout_unmapped();
        test_late_ack();
        test_cyc_drop();
        test_saturate_clear();
        test_reset_midcycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

endmodule
